// File: rtl/tomasula_types.sv
// Shared Tomasulo core types: default CDB geometry and the broadcast lane layout
// consumed by the ROB and reservation stations.
package tomasula_types;

  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CDB_PORTS = 2;

  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_tag_t;

  typedef struct packed {
    logic                valid;
    rob_tag_t            tag;
    logic [DATA_W-1:0]   data;
  } cdb_lane_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-unit result FIFO: circular buffer with modulo pointer wrap, so DEPTH need
// not be a power of two. Flush empties it synchronously.
module cdb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB front end: per-unit result FIFOs, round-robin multi-lane grant onto
// registered broadcast lanes, ROB set-valid decode and sticky duplicate-tag flag.
module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int unsigned NUM_FU     = 6,
  parameter int unsigned NUM_PORTS  = CDB_PORTS,
  parameter int unsigned ROB_DEPTH  = tomasula_types::ROB_DEPTH,
  parameter int unsigned DATA_W     = tomasula_types::DATA_W,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           fu_valid,
  output logic [NUM_FU-1:0]           fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]    fu_data,
  output logic [NUM_PORTS-1:0]        cdb_valid,
  output logic [NUM_PORTS*TAG_W-1:0]  cdb_tag,
  output logic [NUM_PORTS*DATA_W-1:0] cdb_data,
  output logic [ROB_DEPTH-1:0]        set_rob_valid,
  output logic                        dup_tag_err
);

  localparam int unsigned ENT_W = TAG_W + DATA_W;
  localparam int unsigned RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } lane_t;

  logic [NUM_FU-1:0] push, pop, full, empty;
  logic [ENT_W-1:0]  head [NUM_FU];
  lane_t             lane_d [NUM_PORTS];
  lane_t             lane_q [NUM_PORTS];
  logic [RR_W-1:0]   rr_ptr_d, rr_ptr_q;
  logic              dup_d, dup_q;

  function automatic logic [RR_W-1:0] rr_inc(input logic [RR_W-1:0] p);
    return (p == RR_W'(NUM_FU - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO stays not-ready even when its head pops this cycle (no bypass).
  assign fu_ready = ~full & {NUM_FU{rst & ~flush}};
  assign push     = fu_valid & fu_ready;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    cdb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({fu_tag[i*TAG_W +: TAG_W], fu_data[i*DATA_W +: DATA_W]}),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin : arbiter
    logic [RR_W-1:0] idx;
    int unsigned     grants;
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_PORTS; k++) lane_d[k] = '0;
    idx    = rr_ptr_q;
    grants = 0;
    for (int unsigned n = 0; n < NUM_FU; n++) begin
      if (!empty[idx] && grants < NUM_PORTS) begin
        pop[idx] = 1'b1;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
          if (k == grants) begin
            lane_d[k].valid = 1'b1;
            lane_d[k].tag   = head[idx][ENT_W-1 -: TAG_W];
            lane_d[k].data  = head[idx][DATA_W-1:0];
          end
        end
        grants   = grants + 1;
        rr_ptr_d = rr_inc(idx);
      end
      idx = rr_inc(idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) lane_q[k] <= '0;
    end else if (flush) begin
      rr_ptr_q <= '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) lane_q[k] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lane_q   <= lane_d;
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane_out
    assign cdb_valid[k]                   = lane_q[k].valid;
    assign cdb_tag[k*TAG_W +: TAG_W]      = lane_q[k].tag;
    assign cdb_data[k*DATA_W +: DATA_W]   = lane_q[k].data;
  end

  always_comb begin
    set_rob_valid = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++)
      if (lane_q[k].valid) set_rob_valid[lane_q[k].tag] = 1'b1;
  end

  always_comb begin
    dup_d = 1'b0;
    for (int unsigned a = 0; a < NUM_PORTS; a++)
      for (int unsigned b = a + 1; b < NUM_PORTS; b++)
        if (lane_q[a].valid && lane_q[b].valid && lane_q[a].tag == lane_q[b].tag)
          dup_d = 1'b1;
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       dup_q <= 1'b0;
    else if (dup_d) dup_q <= 1'b1;
  end

  assign dup_tag_err = dup_q | dup_d;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a 2-lane instance for the main scenarios and a
// 1-lane instance for fairness/backpressure, sharing clock, reset and flush.
`timescale 1ns/1ps
module tb_cdb_arbiter;

  localparam int NFU = 6;
  localparam int TW  = 3;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic [NFU-1:0]    fu_valid = '0;
  logic [NFU-1:0]    fu_ready;
  logic [NFU*TW-1:0] fu_tag = '0;
  logic [NFU*DW-1:0] fu_data = '0;
  logic [1:0]        cdb_valid;
  logic [2*TW-1:0]   cdb_tag;
  logic [2*DW-1:0]   cdb_data;
  logic [7:0]        set_rob_valid;
  logic              dup_tag_err;

  logic [NFU-1:0]    fu_valid1 = '0;
  logic [NFU-1:0]    fu_ready1;
  logic [NFU*TW-1:0] fu_tag1 = '0;
  logic [NFU*DW-1:0] fu_data1 = '0;
  logic [0:0]        cdb_valid1;
  logic [TW-1:0]     cdb_tag1;
  logic [DW-1:0]     cdb_data1;
  logic [7:0]        set_rob_valid1;
  logic              dup_tag_err1;

  cdb_arbiter #(.NUM_FU(6), .NUM_PORTS(2), .ROB_DEPTH(8), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag), .fu_data(fu_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .set_rob_valid(set_rob_valid), .dup_tag_err(dup_tag_err)
  );

  cdb_arbiter #(.NUM_FU(6), .NUM_PORTS(1), .ROB_DEPTH(8), .DATA_W(32), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid1), .fu_ready(fu_ready1), .fu_tag(fu_tag1), .fu_data(fu_data1),
    .cdb_valid(cdb_valid1), .cdb_tag(cdb_tag1), .cdb_data(cdb_data1),
    .set_rob_valid(set_rob_valid1), .dup_tag_err(dup_tag_err1)
  );

  int total = 0;
  int bad   = 0;

  logic [TW+DW-1:0] exp_q[$];
  logic [TW+DW-1:0] exp1_q0[$];
  logic [TW+DW-1:0] exp1_q1[$];
  logic             alt_check = 1'b0;
  int               exp_fu1 = 0;
  int               grants1 = 0;

  // Lane monitor for the 2-lane instance: each broadcast pops the next expected result.
  logic [TW+DW-1:0] got0, want0;
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      if (cdb_valid[k] === 1'b1) begin
        got0 = {cdb_tag[k*TW +: TW], cdb_data[k*DW +: DW]};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected lane%0d: got tag=%0d data=%h, expected no broadcast",
                   k, got0[34:32], got0[31:0]);
        end else begin
          want0 = exp_q.pop_front();
          if (got0 !== want0) begin
            bad++;
            $display("FAIL sb_lane%0d: got tag=%0d data=%h, expected tag=%0d data=%h",
                     k, got0[34:32], got0[31:0], want0[34:32], want0[31:0]);
          end
        end
      end
    end
  end

  // Lane monitor for the 1-lane instance: per-unit order plus grant alternation.
  logic [TW+DW-1:0] got1, want1;
  int               fu1;
  always @(posedge clk) begin
    #2;
    if (cdb_valid1[0] === 1'b1) begin
      got1 = {cdb_tag1, cdb_data1};
      fu1  = int'(got1[31:24]);
      grants1++;
      if (alt_check) begin
        total++;
        if (fu1 !== exp_fu1) begin
          bad++;
          $display("FAIL rr_alternate: got grant to FU%0d, expected FU%0d", fu1, exp_fu1);
        end
      end
      exp_fu1 = (fu1 == 0) ? 1 : 0;
      total++;
      if (fu1 == 0 && exp1_q0.size() > 0) begin
        want1 = exp1_q0.pop_front();
        if (got1 !== want1) begin
          bad++;
          $display("FAIL sb1_fu0: got %h, expected %h", got1, want1);
        end
      end else if (fu1 == 1 && exp1_q1.size() > 0) begin
        want1 = exp1_q1.pop_front();
        if (got1 !== want1) begin
          bad++;
          $display("FAIL sb1_fu1: got %h, expected %h", got1, want1);
        end
      end else begin
        bad++;
        $display("FAIL sb1_unexpected: got %h from FU%0d, expected no broadcast", got1, fu1);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    fu_valid = '0;
  endtask

  task automatic drive(input int fu, input logic [2:0] tag, input logic [31:0] data,
                       input bit expect_out);
    fu_valid[fu]           = 1'b1;
    fu_tag[fu*TW +: TW]    = tag;
    fu_data[fu*DW +: DW]   = data;
    if (expect_out) exp_q.push_back({tag, data});
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    tick(); tick();
    #1;
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL rst_cdb_valid: got %b, expected 00", cdb_valid); end
    total++; if (set_rob_valid !== 8'h00) begin bad++; $display("FAIL rst_set_rob_valid: got %h, expected 00", set_rob_valid); end
    total++; if (dup_tag_err !== 1'b0) begin bad++; $display("FAIL rst_dup: got %b, expected 0", dup_tag_err); end
    total++; if (fu_ready !== 6'h00) begin bad++; $display("FAIL rst_fu_ready: got %h, expected 00", fu_ready); end
    tick();
    rst = 1'b1;
    #1;
    total++; if (fu_ready !== 6'h3F) begin bad++; $display("FAIL rel_fu_ready: got %h, expected 3f", fu_ready); end
    tick();
    drive(0, 3'd1, 32'h0000_0111, 1'b0);
    drive(1, 3'd2, 32'h0000_0222, 1'b0);
    drive(2, 3'd3, 32'h0000_0333, 1'b0);
    tick();
    idle();
    rst = 1'b0;
    #1;
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL mid_rst_cdb_valid: got %b, expected 00", cdb_valid); end
    total++; if (set_rob_valid !== 8'h00) begin bad++; $display("FAIL mid_rst_set: got %h, expected 00", set_rob_valid); end
    total++; if (dup_tag_err !== 1'b0) begin bad++; $display("FAIL mid_rst_dup: got %b, expected 0", dup_tag_err); end
    total++; if (fu_ready !== 6'h00) begin bad++; $display("FAIL mid_rst_fu_ready: got %h, expected 00", fu_ready); end
    tick();
    rst = 1'b1;
    #1;
    total++; if (fu_ready !== 6'h3F) begin bad++; $display("FAIL mid_rel_fu_ready: got %h, expected 3f", fu_ready); end
    drive(3, 3'd6, 32'h0000_3333, 1'b1);
    tick();
    idle();
    tick();
    total++; if (cdb_valid !== 2'b01) begin bad++; $display("FAIL post_rst_valid: got %b, expected 01", cdb_valid); end
    total++; if (cdb_tag[2:0] !== 3'd6) begin bad++; $display("FAIL post_rst_tag: got %0d, expected 6", cdb_tag[2:0]); end
    total++; if (set_rob_valid !== 8'h40) begin bad++; $display("FAIL post_rst_set: got %h, expected 40", set_rob_valid); end
    tick();
  endtask

  task automatic test_single();
    drive(0, 3'd3, 32'hDEAD_BEEF, 1'b1);
    tick();
    idle();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL single_c1_valid: got %b, expected 00", cdb_valid); end
    tick();
    total++; if (cdb_valid !== 2'b01) begin bad++; $display("FAIL single_valid: got %b, expected 01", cdb_valid); end
    total++; if (cdb_tag[2:0] !== 3'd3) begin bad++; $display("FAIL single_tag: got %0d, expected 3", cdb_tag[2:0]); end
    total++; if (cdb_data[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_data: got %h, expected deadbeef", cdb_data[31:0]); end
    total++; if (set_rob_valid !== 8'h08) begin bad++; $display("FAIL single_set: got %h, expected 08", set_rob_valid); end
    tick();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL single_c3_valid: got %b, expected 00", cdb_valid); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_set [3];
    exp_set = '{8'h03, 8'h0C, 8'h30};
    pulse_flush();
    for (int i = 0; i < NFU; i++) drive(i, 3'(i), 32'hB000_0000 + 32'(i), 1'b1);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL burst_valid c%0d: got %b, expected 11", c + 2, cdb_valid); end
      total++; if (set_rob_valid !== exp_set[c]) begin bad++; $display("FAIL burst_set c%0d: got %h, expected %h", c + 2, set_rob_valid, exp_set[c]); end
    end
    tick();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL burst_end_valid: got %b, expected 00", cdb_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) drive(i, 3'(i + 1), 32'hF000_0000 + 32'(i), 1'b0);
    tick();
    idle();
    flush = 1'b1;
    drive(5, 3'd7, 32'hF000_0005, 1'b0);
    #1;
    total++; if (fu_ready !== 6'h00) begin bad++; $display("FAIL flush_fu_ready: got %h, expected 00", fu_ready); end
    tick();
    flush = 1'b0;
    idle();
    #1;
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL flush_valid: got %b, expected 00", cdb_valid); end
    total++; if (fu_ready !== 6'h3F) begin bad++; $display("FAIL flush_after_ready: got %h, expected 3f", fu_ready); end
    drive(2, 3'd2, 32'h2222_0002, 1'b1);
    tick();
    idle();
    tick();
    total++; if (cdb_valid !== 2'b01) begin bad++; $display("FAIL flush_new_valid: got %b, expected 01", cdb_valid); end
    total++; if (cdb_tag[2:0] !== 3'd2) begin bad++; $display("FAIL flush_new_tag: got %0d, expected 2", cdb_tag[2:0]); end
    total++; if (set_rob_valid !== 8'h04) begin bad++; $display("FAIL flush_new_set: got %h, expected 04", set_rob_valid); end
    tick();
    total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL flush_quiet: got %b, expected 00", cdb_valid); end
  endtask

  task automatic test_dup_tag();
    pulse_flush();
    total++; if (dup_tag_err !== 1'b0) begin bad++; $display("FAIL dup_pre: got %b, expected 0", dup_tag_err); end
    drive(2, 3'd5, 32'hAAAA_0002, 1'b1);
    drive(4, 3'd5, 32'hAAAA_0004, 1'b1);
    tick();
    idle();
    tick();
    total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL dup_valid: got %b, expected 11", cdb_valid); end
    total++; if (cdb_tag !== 6'b101_101) begin bad++; $display("FAIL dup_tags: got %b, expected 101101", cdb_tag); end
    total++; if (set_rob_valid !== 8'h20) begin bad++; $display("FAIL dup_set: got %h, expected 20", set_rob_valid); end
    total++; if (dup_tag_err !== 1'b1) begin bad++; $display("FAIL dup_flag: got %b, expected 1", dup_tag_err); end
    tick();
    pulse_flush();
    #1;
    total++; if (dup_tag_err !== 1'b1) begin bad++; $display("FAIL dup_sticky_flush: got %b, expected 1", dup_tag_err); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size()); end
    rst = 1'b0;
    #1;
    total++; if (dup_tag_err !== 1'b0) begin bad++; $display("FAIL dup_reset: got %b, expected 0", dup_tag_err); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_fairness();
    int         seq0 = 0;
    int         seq1 = 0;
    int         acc  = 0;
    logic       saw_drop0 = 1'b0;
    logic [5:0] rdy;
    alt_check = 1'b1;
    exp_fu1   = 0;
    for (int c = 0; c < 24; c++) begin
      fu_valid1         = 6'b000011;
      fu_tag1[0 +: TW]  = 3'(seq0);
      fu_data1[0 +: DW] = {8'd0, 24'(seq0)};
      fu_tag1[TW +: TW] = 3'(seq1);
      fu_data1[DW +: DW] = {8'd1, 24'(seq1)};
      #1 rdy = fu_ready1;
      if (!rdy[0]) saw_drop0 = 1'b1;
      @(posedge clk);
      if (rdy[0]) begin exp1_q0.push_back({3'(seq0), 8'd0, 24'(seq0)}); seq0++; acc++; end
      if (rdy[1]) begin exp1_q1.push_back({3'(seq1), 8'd1, 24'(seq1)}); seq1++; acc++; end
      @(negedge clk);
    end
    fu_valid1 = '0;
    alt_check = 1'b0;
    repeat (8) tick();
    total++; if (saw_drop0 !== 1'b1) begin bad++; $display("FAIL fair_ready_drop: got %b, expected 1", saw_drop0); end
    total++; if (exp1_q0.size() != 0) begin bad++; $display("FAIL fair_fu0_lost: got %0d pending, expected 0", exp1_q0.size()); end
    total++; if (exp1_q1.size() != 0) begin bad++; $display("FAIL fair_fu1_lost: got %0d pending, expected 0", exp1_q1.size()); end
    total++; if (grants1 != acc) begin bad++; $display("FAIL fair_count: got %0d grants, expected %0d", grants1, acc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000ns, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_flush();
    test_dup_tag();
    test_fairness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus front end for the Tomasulo core. It sits between the functional units (ALU reservation stations, branch unit, LSQ) and the CDB/ROB valid logic. Each unit gets a small result FIFO with valid/ready backpressure. A round-robin arbiter drains up to NUM_PORTS results per cycle onto registered broadcast lanes and produces the per-ROB-entry set-valid vector. This replaces direct, unarbitrated tag-indexed CDB writes and supports any unit count, lane count and ROB depth.

## Interface
Parameters:
- NUM_FU, 6, number of producing units
- NUM_PORTS, 2, broadcast lanes per cycle (1..NUM_FU)
- ROB_DEPTH, 8, ROB entries, power of two; TAG_W = $clog2(ROB_DEPTH)
- DATA_W, 32, result width
- FIFO_DEPTH, 2, per-unit result FIFO entries (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous mispredict flush, drops all buffered and registered results
- fu_valid  in  NUM_FU  unit i presents a result
- fu_ready  out  NUM_FU  unit i FIFO can accept
- fu_tag  in  NUM_FU*TAG_W  ROB tag per unit, unit i at [i*TAG_W +: TAG_W]
- fu_data  in  NUM_FU*DATA_W  result per unit
- cdb_valid  out  NUM_PORTS  lane k broadcasting
- cdb_tag  out  NUM_PORTS*TAG_W  lane k tag
- cdb_data  out  NUM_PORTS*DATA_W  lane k data
- set_rob_valid  out  ROB_DEPTH  OR over valid lanes of onehot(cdb_tag)
- dup_tag_err  out  1  sticky: two valid lanes carried the same tag in one cycle

## Operation
- Enqueue: a result is accepted at the edge when fu_valid[i] & fu_ready[i]. fu_ready[i] = (count[i] < FIFO_DEPTH) & rst & ~flush. There is no full-FIFO bypass: a full FIFO deasserts ready even if it is dequeued in the same cycle.
- Arbitration is combinational over the FIFO heads. Scan index j = (rr_ptr + n) mod NUM_FU for n = 0..NUM_FU-1. The first NUM_PORTS non-empty FIFOs are granted in scan order. Lane k gets the k-th grant; unused lanes are invalid.
- Granted FIFOs pop at the edge. In the same edge the lane registers load valid/tag/data.
- rr_ptr_next = (last granted index + 1) mod NUM_FU. It holds when there is no grant. Width is $clog2(NUM_FU), with explicit modulo wrap for non-power-of-two NUM_FU.
- Simultaneous push and pop on the same FIFO in one cycle is legal; count is unchanged.
- set_rob_valid is combinational from the registered lanes.
- dup_tag_err compares all valid lane pairs on the registered lanes. It sets and holds until reset. Both lanes still broadcast.
- Flush (synchronous, priority over everything except reset):
  - all FIFO counts and pointers go to 0, all cdb_valid go to 0 at that edge, rr_ptr goes to 0;
  - fu_valid in the flush cycle is ignored (fu_ready = 0);
  - dup_tag_err is not cleared.
- Reset (asynchronous, rst = 0, also mid-operation):
  - FIFOs empty, rr_ptr = 0, cdb_valid = 0, cdb_tag = 0, cdb_data = 0, set_rob_valid = 0, dup_tag_err = 0, fu_ready = 0;
  - fu_ready rises to all ones combinationally on deassertion.

## Timing
- Latency: result accepted at end of cycle 0 → granted in cycle 1 → visible on the CDB lanes in cycle 2. Minimum latency is 2 cycles; lanes are fully registered.
- Throughput: NUM_PORTS results per cycle aggregate, 1 per unit per cycle.
- A unit with a full FIFO sees ready = 0 for at least one cycle and must hold valid/tag/data until accepted.
- Worst-case wait for a continuously non-empty unit: ceil(NUM_FU/NUM_PORTS) - 1 cycles between its grants.
- FIFO pointer wrap follows FIFO_DEPTH (modulo; not required to be a power of two).

## Structure
- Shared package (tomasula_types): cdb_lane_t struct {valid, tag, data} sized by package constants ROB_DEPTH and DATA_W; add the constant CDB_PORTS.
- Sub-module cdb_fifo: one instance per unit, parameters DEPTH and WIDTH (TAG_W+DATA_W). Interface: push, pop, full, empty, head, flush. Same clk/rst convention.
- Arbiter, lane registers, set-valid decode and dup check live in cdb_arbiter.

## Test plan
- Reset mid-traffic: 3 entries queued, drive rst = 0 → cdb_valid = 0, set_rob_valid = 8'h00, dup_tag_err = 0. After release, fu_ready = 6'h3F, and a fresh FU3 result is granted on lane 0 (rr_ptr = 0).
- Single result: FU0 tag 3 data 32'hDEADBEEF in cycle 0 → cycle 2: cdb_valid = 2'b01, cdb_tag[0] = 3, cdb_data[0] = 32'hDEADBEEF, set_rob_valid = 8'h08. Cycle 3: cdb_valid = 0.
- Burst: FU0..FU5 valid in one cycle with tags 0..5 → cycles 2/3/4 broadcast {FU0,FU1},{FU2,FU3},{FU4,FU5}; set_rob_valid = 8'h03, 8'h0C, 8'h30.
- Fairness/backpressure: NUM_PORTS = 1, FU0 and FU1 valid every cycle → grants alternate FU0, FU1, FU0…. fu_ready[0] drops once 2 entries are queued, and no accepted result is lost or duplicated (scoreboard).
- Flush: 4 results buffered, pulse flush → next cycle cdb_valid = 0, fu_ready = 6'h3F, none of the 4 tags ever appears; FU2 result after the flush broadcasts 2 cycles later.
- Duplicate tag: FU2 and FU4 both tag 5 in the same cycle → cycle 2: both lanes carry tag 5, set_rob_valid = 8'h20, dup_tag_err = 1, which stays 1 through a flush until reset.
